// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and address helpers for the data-memory
// read-modify-write arbiter.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bit of reqN_strb that selects zero extension on loads.
  localparam int STRB_UNS_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic int dmem_addr_w(input int depth);
    return $clog2(depth) + 2;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic res;
    case (size)
      SZ_BYTE: res = 1'b0;
      SZ_HALF: res = lo[0];
      default: res = |lo;
    endcase
    return res;
  endfunction

  // Low address bits forced to the natural alignment of the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] res;
    case (size)
      SZ_BYTE: res = lo;
      SZ_HALF: res = {lo[1], 1'b0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: load extraction with sign/zero extension
// and sub-word store merge into the previously read word.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [31:0] shifted_s;

  // Lane selection and extension for loads, lane replacement for stores.
  always_comb begin
    shifted_s    = rd_word_i >> {addr_lo_i, 3'b000};
    load_data_o  = shifted_s;
    store_word_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = unsigned_i ? {24'h000000, shifted_s[7:0]}
                                 : {{24{shifted_s[7]}}, shifted_s[7:0]};
        store_word_o = rd_word_i;
        store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_data_o = unsigned_i ? {16'h0000, shifted_s[15:0]}
                                 : {{16{shifted_s[15]}}, shifted_s[15:0]};
        store_word_o = rd_word_i;
        store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_data_o  = shifted_s;
        store_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_rmw_arbiter.sv
// Two-port round-robin front end for a 1R1W word memory: extended loads and
// read-modify-write sub-word stores. Build option DMEM_MISALIGN_TRAP_EN makes
// misaligned accesses return an error instead of being force-aligned.
module dmem_rmw_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH = 4,
  parameter int ADDR_W    = dmem_addr_w(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  input  logic [2:0]        req0_strb,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  input  logic [2:0]        req1_strb,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_din,
  output logic              mem_we,
  input  logic [31:0]       mem_rd_dout
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              rsp0_valid_q, rsp1_valid_q;
  logic [31:0]       rsp0_rdata_q, rsp1_rdata_q;
  logic              rsp0_err_q, rsp1_err_q;

  logic              any_s, gnt_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [31:0]       sel_wdata_s;
  logic [2:0]        sel_strb_s;
  logic [1:0]        sel_size_s;
  logic              rsp_fire_s, rsp_port_s, rsp_err_s;
  logic [31:0]       rsp_data_s;
  logic [31:0]       load_data_s, store_word_s;

  // ptr_q remembers the last granted port; the other one wins a tie.
  always_comb begin
    any_s       = req0_valid | req1_valid;
    gnt_s       = (req0_valid & req1_valid) ? ~ptr_q : ~req0_valid;
    sel_we_s    = gnt_s ? req1_we    : req0_we;
    sel_addr_s  = gnt_s ? req1_addr  : req0_addr;
    sel_wdata_s = gnt_s ? req1_wdata : req0_wdata;
    sel_strb_s  = gnt_s ? req1_strb  : req0_strb;
    sel_size_s  = (sel_strb_s[1:0] == 2'b11) ? SZ_WORD : sel_strb_s[1:0];
    req0_ready  = (state_q == ST_IDLE) && req0_valid && !gnt_s;
    req1_ready  = (state_q == ST_IDLE) && req1_valid && gnt_s;
  end

  dmem_lane_unit u_lane (
    .rd_word_i    (mem_rd_dout),
    .addr_lo_i    (addr_q[1:0]),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data_s),
    .store_word_o (store_word_s)
  );

  // Memory port is driven straight from state and latched address.
  always_comb begin
    mem_rd_addr = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wr_addr = {addr_q[ADDR_W-1:2], 2'b00};
    mem_we      = (state_q == ST_WRITE) || ((state_q == ST_MERGE) && we_q);
    mem_wr_din  = (state_q == ST_WRITE) ? wdata_q : store_word_s;
  end

  // Next-state logic, request latching and response generation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rsp_fire_s = 1'b0;
    rsp_port_s = port_q;
    rsp_err_s  = 1'b0;
    rsp_data_s = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          ptr_d   = gnt_s;
          port_d  = gnt_s;
          we_d    = sel_we_s;
          wdata_d = sel_wdata_s;
          size_d  = sel_size_s;
          uns_d   = sel_strb_s[STRB_UNS_BIT];
          addr_d  = {sel_addr_s[ADDR_W-1:2], align_lo(sel_size_s, sel_addr_s[1:0])};
`ifdef DMEM_MISALIGN_TRAP_EN
          if (is_misaligned(sel_size_s, sel_addr_s[1:0])) begin
            state_d    = ST_RESP;
            rsp_fire_s = 1'b1;
            rsp_port_s = gnt_s;
            rsp_err_s  = 1'b1;
          end else if (sel_we_s && (sel_size_s == SZ_WORD)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
`else
          if (sel_we_s && (sel_size_s == SZ_WORD)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: state_d = ST_MERGE;
      ST_MERGE: begin
        state_d    = ST_RESP;
        rsp_fire_s = 1'b1;
        rsp_data_s = we_q ? 32'h0000_0000 : load_data_s;
      end
      ST_WRITE: begin
        state_d    = ST_RESP;
        rsp_fire_s = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched request; responses registered so they pulse during RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= 32'h0000_0000;
      rsp1_rdata_q <= 32'h0000_0000;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rsp0_valid_q <= rsp_fire_s && !rsp_port_s;
      rsp1_valid_q <= rsp_fire_s && rsp_port_s;
      if (rsp_fire_s && !rsp_port_s) begin
        rsp0_rdata_q <= rsp_data_s;
        rsp0_err_q   <= rsp_err_s;
      end else begin
        rsp0_rdata_q <= rsp0_rdata_q;
        rsp0_err_q   <= rsp0_err_q;
      end
      if (rsp_fire_s && rsp_port_s) begin
        rsp1_rdata_q <= rsp_data_s;
        rsp1_err_q   <= rsp_err_s;
      end else begin
        rsp1_rdata_q <= rsp1_rdata_q;
        rsp1_err_q   <= rsp1_err_q;
      end
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_dmem_rmw_arbiter.sv
// Directed self-checking bench for dmem_rmw_arbiter with a behavioural
// 1R1W memory; expectations follow DMEM_MISALIGN_TRAP_EN when defined.
module tb_dmem_rmw_arbiter;

  localparam int AW = 4;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic [31:0] WORD4_AFTER_T5 = 32'hDEAD_AAEF;
`else
  localparam logic [31:0] WORD4_AFTER_T5 = 32'h5555_AAEF;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [31:0]   req0_wdata = 32'h0;
  logic [2:0]    req0_strb = 3'b000;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [31:0]   req1_wdata = 32'h0;
  logic [2:0]    req1_strb = 3'b000;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0]   rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [31:0]   mem_wr_din;
  logic          mem_we;
  logic [31:0]   mem_rd_dout;
  logic          mem_clr = 1'b1;
  logic [31:0]   mem_q [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_rmw_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_strb(req0_strb),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_strb(req1_strb),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_din(mem_wr_din), .mem_we(mem_we), .mem_rd_dout(mem_rd_dout)
  );

  // Behavioural 1R1W memory: registered read, one-cycle latency.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 32'h0;
    end else if (mem_we) begin
      mem_q[mem_wr_addr[3:2]] <= mem_wr_din;
    end
    mem_rd_dout <= mem_q[mem_rd_addr[3:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Presents a request at a negedge, checks it is accepted, returns at T+1.
  task automatic issue(input int port, input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [2:0] strb);
    if (port == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wd; req0_strb = strb;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wd; req1_strb = strb;
    end
    #1;
    chk("accept_ready", {31'h0, (port == 0) ? req0_ready : req1_ready}, 32'h1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] obs4, exp4;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp0_valid", {31'h0, rsp0_valid}, 32'h0);
    chk("rst_rsp1_valid", {31'h0, rsp1_valid}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_rsp0_rdata", rsp0_rdata, 32'h0);
    chk("rst_rsp1_err", {31'h0, rsp1_err}, 32'h0);
    mem_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nxt();

    // 1: word store
    issue(0, 1'b1, 4'h4, 32'hDEAD_BEEF, 3'b010);
    chk("t1_we", {31'h0, mem_we}, 32'h1);
    chk("t1_wr_addr", {28'h0, mem_wr_addr}, 32'h4);
    chk("t1_din", mem_wr_din, 32'hDEAD_BEEF);
    nxt();
    chk("t1_rsp0_valid", {31'h0, rsp0_valid}, 32'h1);
    chk("t1_rsp0_err", {31'h0, rsp0_err}, 32'h0);
    chk("t1_rsp1_valid", {31'h0, rsp1_valid}, 32'h0);
    nxt();

    // 2: byte store read-modify-write
    issue(0, 1'b1, 4'h5, 32'h0000_00AA, 3'b000);
    chk("t2_read_we", {31'h0, mem_we}, 32'h0);
    chk("t2_rd_addr", {28'h0, mem_rd_addr}, 32'h4);
    nxt();
    chk("t2_merge_we", {31'h0, mem_we}, 32'h1);
    chk("t2_din", mem_wr_din, 32'hDEAD_AAEF);
    chk("t2_wr_addr", {28'h0, mem_wr_addr}, 32'h4);
    nxt();
    chk("t2_rsp0_valid", {31'h0, rsp0_valid}, 32'h1);
    chk("t2_rsp0_rdata", rsp0_rdata, 32'h0);
    nxt();

    // 3: loads with extension
    issue(0, 1'b0, 4'h5, 32'h0, 3'b000);
    nxt(); nxt();
    chk("t3_lb_valid", {31'h0, rsp0_valid}, 32'h1);
    chk("t3_lb_rdata", rsp0_rdata, 32'hFFFF_FFAA);
    nxt();
    issue(0, 1'b0, 4'h5, 32'h0, 3'b100);
    nxt(); nxt();
    chk("t3_lbu_rdata", rsp0_rdata, 32'h0000_00AA);
    nxt();
    issue(0, 1'b0, 4'h6, 32'h0, 3'b001);
    nxt(); nxt();
    chk("t3_lh_rdata", rsp0_rdata, 32'hFFFF_DEAD);
    nxt();
    chk("t3_lh_hold_valid", {31'h0, rsp0_valid}, 32'h0);
    chk("t3_lh_hold_rdata", rsp0_rdata, 32'hFFFF_DEAD);

    // Port 1 alone: word store to word 0
    issue(1, 1'b1, 4'h0, 32'h1234_5678, 3'b010);
    chk("p1_we", {31'h0, mem_we}, 32'h1);
    chk("p1_wr_addr", {28'h0, mem_wr_addr}, 32'h0);
    nxt();
    chk("p1_rsp1_valid", {31'h0, rsp1_valid}, 32'h1);
    chk("p1_rsp0_valid", {31'h0, rsp0_valid}, 32'h0);
    nxt();

    // 4: both ports continuously valid -> 0,1,0,1 every 4 cycles
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'h4; req0_strb = 3'b010;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'h4; req1_strb = 3'b101;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      obs4 = {req0_ready, req1_ready, rsp0_valid, rsp1_valid};
      exp4 = {(k % 8) == 0, (k % 8) == 4, (k % 8) == 3, (k % 8) == 7};
      chk($sformatf("t4_rr_k%0d", k), {28'h0, obs4}, {28'h0, exp4});
      if ((k % 8) == 3) chk("t4_rsp0_rdata", rsp0_rdata, 32'hDEAD_AAEF);
      if ((k % 8) == 7) chk("t4_rsp1_rdata", rsp1_rdata, 32'h0000_AAEF);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    nxt();

    // 5: misaligned half store to 0x7
    issue(0, 1'b1, 4'h7, 32'h0000_5555, 3'b001);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("t5_trap_valid", {31'h0, rsp0_valid}, 32'h1);
    chk("t5_trap_err", {31'h0, rsp0_err}, 32'h1);
    chk("t5_trap_rdata", rsp0_rdata, 32'h0);
    chk("t5_trap_we", {31'h0, mem_we}, 32'h0);
    nxt();
    chk("t5_trap_we2", {31'h0, mem_we}, 32'h0);
`else
    chk("t5_read_we", {31'h0, mem_we}, 32'h0);
    nxt();
    chk("t5_merge_we", {31'h0, mem_we}, 32'h1);
    chk("t5_wr_addr", {28'h0, mem_wr_addr}, 32'h4);
    chk("t5_din", mem_wr_din, 32'h5555_AAEF);
    nxt();
    chk("t5_valid", {31'h0, rsp0_valid}, 32'h1);
    chk("t5_err", {31'h0, rsp0_err}, 32'h0);
`endif
    nxt();
    issue(0, 1'b0, 4'h4, 32'h0, 3'b010);
    nxt(); nxt();
    chk("t5_readback", rsp0_rdata, WORD4_AFTER_T5);
    nxt();

    // 6: reset during READ of a byte store aborts it
    issue(0, 1'b1, 4'h4, 32'h0000_0077, 3'b000);
    chk("t6_read_we", {31'h0, mem_we}, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_rdata", rsp0_rdata, 32'h0);
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk("t6_abort_we", {31'h0, mem_we}, 32'h0);
      chk("t6_abort_rsp", {31'h0, rsp0_valid}, 32'h0);
    end
    rst = 1'b1;
    nxt();
    chk("t6_mem_unchanged", mem_q[1], WORD4_AFTER_T5);
    issue(0, 1'b0, 4'h4, 32'h0, 3'b010);
    nxt(); nxt();
    chk("t6_post_valid", {31'h0, rsp0_valid}, 32'h1);
    chk("t6_post_rdata", rsp0_rdata, WORD4_AFTER_T5);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_rmw_arbiter.md
Name: dmem_rmw_arbiter

Overview:
Controller that shares the single word-wide 1R1W data memory (mem_1r1w) between two requesters: port 0 is the core LSU, port 1 is the debug/DMA side. It performs natural-width loads with sign or zero extension. Byte and halfword stores are done as read-modify-write, so neighbouring bytes in the word are preserved. One operation is in flight at a time, and a round-robin arbiter picks the next request.

Parameters:
MEM_DEPTH, 4, number of 32-bit words in the memory
ADDR_W, $clog2(MEM_DEPTH)+2, byte-address width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_we  in  1  1 = store, 0 = load
req0_addr  in  ADDR_W  byte address
req0_wdata  in  32  store data, right-aligned
req0_strb  in  3  [1:0] size: 00 byte, 01 half, 10 word, 11 treated as word; [2] unsigned load
rsp0_valid  out  1  one-cycle response pulse
rsp0_rdata  out  32  extended load data; 0 for stores
rsp0_err  out  1  misaligned access flag, valid when rsp0_valid is high
req1_* / rsp1_*  same set as port 0, for port 1
mem_rd_addr  out  ADDR_W  word-aligned byte address, [1:0] = 0
mem_wr_addr  out  ADDR_W  word-aligned byte address, [1:0] = 0
mem_wr_din  out  32  full word to write
mem_we  out  1  memory write enable
mem_rd_dout  in  32  raw read word, valid 1 cycle after mem_rd_addr is presented

Behaviour:
- Reset (async, rst=0): state IDLE; all rsp*_valid, rsp*_rdata, rsp*_err = 0; mem_we = 0; round-robin pointer gives port 0 priority. Reset during any state aborts the operation: no write, no response.
- Handshake: reqN_ready = (state==IDLE) && granted(N). Requester holds valid and payload stable until ready. Accepting a request latches we, addr, wdata and strb. Responses have no backpressure.
- Arbitration: happens only in IDLE. A single valid requester wins. If both are valid, the port not granted last wins. The pointer updates on acceptance only.
- States: IDLE, READ, MERGE, WRITE, RESP. Accept cycle = T.
  - Load: READ at T+1 drives mem_rd_addr. MERGE at T+2 shifts mem_rd_dout right by addr[1:0]*8, extends, and registers the result. RESP at T+3: rsp_valid=1. IDLE at T+4.
  - Word store: WRITE at T+1 with mem_we=1 and din = wdata. RESP at T+2.
  - Byte/half store: READ at T+1. MERGE at T+2 with mem_we=1; din = read word with the selected lane(s) replaced by wdata[7:0] or [15:0]. RESP at T+3.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0): see Optional Feature.
- Memory outputs are combinational from state and latched address, so mem_we is high for exactly one cycle per store.
- Responses route only to the port that was granted. rsp_rdata holds its value until the next response to that port.
- No read/write hazard exists, because one operation is outstanding at a time.

Optional Feature:
Macro DMEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access goes IDLE → RESP at T+1 with rsp_err=1, rdata=0, and no memory access.
- Undefined: the address is forced to natural alignment (half clears [0], word clears [1:0]) and the access proceeds normally; rsp*_err is tied to 0.

Decomposition:
- Package dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the strb unsigned-bit index, the state enum, and ADDR_W computation.
- Sub-module dmem_lane_unit (combinational): load extraction/extension and store lane merge. Shared by MERGE for both loads and stores.

Test Plan:
1. After reset, port 0 word store 0xDEADBEEF to 0x4 → mem_we at T+1 with wr_addr 0x4, din 0xDEADBEEF; rsp0_valid at T+2, err 0.
2. Port 0 byte store 0xAA to 0x5, strb 000 → read at T+1; at T+2 mem_we with din 0xDEADAAEF; rsp0_valid at T+3.
3. Load byte 0x5 with strb 000 → rsp0_rdata 0xFFFFFFAA at T+3; strb 100 → 0x000000AA. Load half 0x6 with strb 001 → 0xFFFFDEAD.
4. Both ports valid continuously with loads → grants go 0,1,0,1; a new acceptance every 4 cycles; each response only on the granted port.
5. Half store to 0x7:
   - With DMEM_MISALIGN_TRAP_EN: rsp_err=1 at T+1, no mem_we.
   - Without it: write lands at 0x6 lanes [31:16].
6. rst pulled low while in READ of a byte store → mem_we never asserts, memory word unchanged, no rsp; after release req0_ready returns in IDLE.
